// File: rtl/psum_column_accumulator.sv
// rtl/psum_column_accumulator.sv - splits column partial sums into 1/2/4 lanes and accumulates them over N passes
module psum_column_accumulator #(
    parameter int ACC_W = 64,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           cfg_weight_width,
    input  logic                 cfg_signed,
    input  logic [CNT_W-1:0]     cfg_passes,
    input  logic [51:0]          psum_in,
    input  logic                 psum_valid,
    output logic                 psum_ready,
    output logic [4*ACC_W-1:0]   out_data,
    output logic [1:0]           out_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               mode_q, mode_d;
    logic                     signed_q, signed_d;
    logic [CNT_W-1:0]         passes_q, passes_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         cnt_inc;
    logic [3:0][ACC_W-1:0]    acc_q, acc_d;
    logic [3:0][ACC_W-1:0]    lane_val;
    logic                     psum_ready_q, psum_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d;

    function automatic logic [ACC_W-1:0] ext13(input logic [12:0] v, input logic s);
        return {{(ACC_W-13){s & v[12]}}, v};
    endfunction

    function automatic logic [ACC_W-1:0] ext26(input logic [25:0] v, input logic s);
        return {{(ACC_W-26){s & v[25]}}, v};
    endfunction

    function automatic logic [ACC_W-1:0] ext52(input logic [51:0] v, input logic s);
        return {{(ACC_W-52){s & v[51]}}, v};
    endfunction

    // Priority decode: the widest weight bit wins, anything else falls to 2b/1b packing.
    function automatic logic [1:0] decode_mode(input logic [3:0] w);
        if (w[3]) begin
            return 2'd0;
        end else if (w[2]) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

    always_comb begin
        lane_val = '0;
        case (mode_q)
            2'd0: begin
                lane_val[0] = ext52(psum_in[51:0], signed_q);
            end
            2'd1: begin
                lane_val[0] = ext26(psum_in[25:0], signed_q);
                lane_val[1] = ext26(psum_in[51:26], signed_q);
            end
            default: begin
                lane_val[0] = ext13(psum_in[12:0], signed_q);
                lane_val[1] = ext13(psum_in[25:13], signed_q);
                lane_val[2] = ext13(psum_in[38:26], signed_q);
                lane_val[3] = ext13(psum_in[51:39], signed_q);
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        signed_d = signed_q;
        passes_d = passes_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        cnt_inc  = cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d   = decode_mode(cfg_weight_width);
                    signed_d = cfg_signed;
                    passes_d = cfg_passes;
                    cnt_d    = '0;
                    acc_d    = '0;
                    state_d  = (cfg_passes == '0) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (psum_valid) begin
                    for (int i = 0; i < 4; i++) begin
                        acc_d[i] = acc_q[i] + lane_val[i];
                    end
                    cnt_d = cnt_inc;
                    if (cnt_inc == passes_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        psum_ready_d = (state_d == ACCUM);
        out_valid_d  = (state_d == DRAIN);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= 2'd0;
            signed_q     <= 1'b0;
            passes_q     <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            psum_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            signed_q     <= signed_d;
            passes_q     <= passes_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            psum_ready_q <= psum_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign psum_ready = psum_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign out_data   = acc_q;
    assign out_mode   = mode_q;

endmodule

// File: tb/tb_psum_column_accumulator.sv
// tb/tb_psum_column_accumulator.sv - self-checking bench for psum_column_accumulator
module tb_psum_column_accumulator;

    localparam int ACC_W = 64;
    localparam int CNT_W = 16;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [3:0]         cfg_weight_width;
    logic               cfg_signed;
    logic [CNT_W-1:0]   cfg_passes;
    logic [51:0]        psum_in;
    logic               psum_valid;
    logic               psum_ready;
    logic [4*ACC_W-1:0] out_data;
    logic [1:0]         out_mode;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    psum_column_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .cfg_weight_width (cfg_weight_width),
        .cfg_signed       (cfg_signed),
        .cfg_passes       (cfg_passes),
        .psum_in          (psum_in),
        .psum_valid       (psum_valid),
        .psum_ready       (psum_ready),
        .out_data         (out_data),
        .out_mode         (out_mode),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]        w;
        logic              s;
        logic [15:0]       p;
        logic [3:0][51:0]  b;
        logic [3:0][63:0]  e;
        logic [1:0]        m;
    } vec_t;

    int          total_cnt;
    int          pass_cnt;
    logic [51:0] job_beats[$];
    vec_t        vecs[12];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] w, input logic s, input logic [15:0] p,
                                input logic [3:0][51:0] b, input logic [3:0][63:0] e,
                                input logic [1:0] m);
        vec_t v;
        v.w = w; v.s = s; v.p = p; v.b = b; v.e = e; v.m = m;
        return v;
    endfunction

    function automatic logic [1:0] ref_mode(input logic [3:0] w);
        if (w[3]) return 2'd0;
        if (w[2]) return 2'd1;
        return 2'd2;
    endfunction

    // Lane value straight from field width and offset: mask the field, then subtract 2^n if it is negative.
    function automatic logic [63:0] ref_lane(input logic [51:0] beat, input logic [1:0] mode,
                                             input logic sgn, input int lane);
        int          n;
        int          nl;
        logic [63:0] v;
        logic [63:0] span;
        n  = 52 >> mode;
        nl = 1 << mode;
        if (lane >= nl) return 64'd0;
        span = 64'd1 << n;
        v = ({12'd0, beat} >> (lane * n)) & (span - 64'd1);
        if (sgn && v[n-1]) v = v - span;
        return v;
    endfunction

    function automatic logic [51:0] rand52();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[51:0];
    endfunction

    task automatic run_job(input logic [3:0] w, input logic s, input int p, input bit gaps);
        start = 1'b1;
        cfg_weight_width = w;
        cfg_signed = s;
        cfg_passes = p[15:0];
        @(negedge clk);
        start = 1'b0;
        cfg_weight_width = 4'($urandom);
        cfg_signed = 1'($urandom);
        cfg_passes = 16'($urandom);
        chk("start_busy", {255'd0, busy}, 256'd1);
        chk("start_ready", {255'd0, psum_ready}, (p > 0) ? 256'd1 : 256'd0);
        chk("start_valid", {255'd0, out_valid}, (p == 0) ? 256'd1 : 256'd0);
        chk("start_clear", out_data, 256'd0);
        for (int k = 0; k < p; k++) begin
            if (gaps && ($urandom % 3 == 0)) begin
                psum_valid = 1'b0;
                psum_in = rand52();
                @(negedge clk);
            end
            if (k == p - 1) begin
                chk("pre_last_valid", {255'd0, out_valid}, 256'd0);
                chk("pre_last_ready", {255'd0, psum_ready}, 256'd1);
            end else if (p <= 64) begin
                chk("beat_ready", {255'd0, psum_ready}, 256'd1);
            end
            psum_valid = 1'b1;
            psum_in = job_beats[k];
            @(negedge clk);
        end
        psum_valid = 1'b0;
        psum_in = rand52();
        chk("done_valid", {255'd0, out_valid}, 256'd1);
        chk("done_ready", {255'd0, psum_ready}, 256'd0);
    endtask

    task automatic finish_job(input logic [255:0] exp, input logic [1:0] m);
        chk("out_data", out_data, exp);
        chk("out_mode", {254'd0, out_mode}, {254'd0, m});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hs_valid", {255'd0, out_valid}, 256'd0);
        chk("hs_busy", {255'd0, busy}, 256'd0);
        chk("hs_hold", out_data, exp);
    endtask

    initial begin
        logic [3:0][63:0] exp;
        logic [3:0]       w;
        logic             s;
        int               p;
        total_cnt = 0;
        pass_cnt = 0;
        rst_n = 1'b0;
        start = 1'b0;
        cfg_weight_width = 4'd0;
        cfg_signed = 1'b0;
        cfg_passes = '0;
        psum_in = '0;
        psum_valid = 1'b0;
        out_ready = 1'b0;

        vecs[0]  = mk(4'b1000, 1'b0, 16'd3, {52'd0, 52'd300, 52'd200, 52'd100},
                      {64'd0, 64'd0, 64'd0, 64'd600}, 2'd0);
        vecs[1]  = mk(4'b0100, 1'b1, 16'd2, {4{26'd5, 26'h3FF_FFFF}},
                      {64'd0, 64'd0, 64'd10, 64'hFFFF_FFFF_FFFF_FFFE}, 2'd1);
        vecs[2]  = mk(4'b0100, 1'b0, 16'd2, {4{26'd5, 26'h3FF_FFFF}},
                      {64'd0, 64'd0, 64'd10, 64'h7FF_FFFE}, 2'd1);
        vecs[3]  = mk(4'b0001, 1'b0, 16'd4, {4{13'h1FFF, 13'd3, 13'd2, 13'd1}},
                      {64'd32764, 64'd12, 64'd8, 64'd4}, 2'd2);
        vecs[4]  = mk(4'b0001, 1'b1, 16'd4, {4{13'h1FFF, 13'd3, 13'd2, 13'd1}},
                      {64'hFFFF_FFFF_FFFF_FFFC, 64'd12, 64'd8, 64'd4}, 2'd2);
        vecs[5]  = mk(4'b0100, 1'b1, 16'd0, {4{52'hF_FFFF_FFFF_FFFF}},
                      {4{64'd0}}, 2'd1);
        vecs[6]  = mk(4'b1000, 1'b1, 16'd1, {4{52'hF_FFFF_FFFF_FFFF}},
                      {64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 2'd0);
        vecs[7]  = mk(4'b1000, 1'b1, 16'd3, {4{52'hF_FFFF_FFFF_FFFF}},
                      {64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD}, 2'd0);
        vecs[8]  = mk(4'b0000, 1'b0, 16'd1, {4{13'h1FFF, 13'd3, 13'd2, 13'd1}},
                      {64'd8191, 64'd3, 64'd2, 64'd1}, 2'd2);
        vecs[9]  = mk(4'b1111, 1'b0, 16'd1, {4{52'h8_0000_0000_0001}},
                      {64'd0, 64'd0, 64'd0, 64'h8_0000_0000_0001}, 2'd0);
        vecs[10] = mk(4'b0110, 1'b1, 16'd1, {4{26'h200_0000, 26'd7}},
                      {64'd0, 64'd0, 64'hFFFF_FFFF_FE00_0000, 64'd7}, 2'd1);
        vecs[11] = mk(4'b0010, 1'b1, 16'd2, {4{13'h1000, 13'h1000, 13'h1000, 13'h1000}},
                      {4{64'hFFFF_FFFF_FFFF_E000}}, 2'd2);

        repeat (3) @(negedge clk);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_ready", {255'd0, psum_ready}, 256'd0);
        chk("rst_valid", {255'd0, out_valid}, 256'd0);
        chk("rst_data", out_data, 256'd0);
        chk("rst_mode", {254'd0, out_mode}, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            job_beats.delete();
            for (int k = 0; k < int'(vecs[i].p); k++) job_beats.push_back(vecs[i].b[k % 4]);
            run_job(vecs[i].w, vecs[i].s, int'(vecs[i].p), 1'b0);
            finish_job(vecs[i].e, vecs[i].m);
        end

        for (int j = 0; j < 24; j++) begin
            w = 4'($urandom);
            s = 1'($urandom);
            p = $urandom_range(0, 7);
            exp = '0;
            job_beats.delete();
            for (int k = 0; k < p; k++) begin
                job_beats.push_back(rand52());
                for (int l = 0; l < 4; l++) exp[l] = exp[l] + ref_lane(job_beats[k], ref_mode(w), s, l);
            end
            run_job(w, s, p, 1'b1);
            finish_job(exp, ref_mode(w));
        end

        // Backpressure in DRAIN: psum and start traffic must be ignored while the result is held.
        job_beats.delete();
        exp = '0;
        for (int k = 0; k < 2; k++) begin
            job_beats.push_back(rand52());
            for (int l = 0; l < 4; l++) exp[l] = exp[l] + ref_lane(job_beats[k], 2'd2, 1'b1, l);
        end
        run_job(4'b0010, 1'b1, 2, 1'b0);
        for (int c = 0; c < 5; c++) begin
            psum_valid = 1'b1;
            psum_in = rand52();
            start = c[0];
            cfg_weight_width = 4'b1000;
            cfg_passes = 16'd1;
            @(negedge clk);
            chk("bp_ready", {255'd0, psum_ready}, 256'd0);
            chk("bp_valid", {255'd0, out_valid}, 256'd1);
            chk("bp_data", out_data, exp);
        end
        psum_valid = 1'b0;
        start = 1'b0;
        finish_job(exp, 2'd2);
        @(negedge clk);
        chk("bp_no_queue", {255'd0, busy}, 256'd0);
        chk("bp_retain", out_data, exp);

        // Reset mid-job after two of four beats.
        job_beats.delete();
        job_beats.push_back(52'd5);
        job_beats.push_back(52'd6);
        start = 1'b1;
        cfg_weight_width = 4'b0001;
        cfg_signed = 1'b0;
        cfg_passes = 16'd4;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            psum_valid = 1'b1;
            psum_in = job_beats[k];
            @(negedge clk);
        end
        chk("mid_partial", out_data, {64'd0, 64'd0, 64'd0, 64'd11});
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {255'd0, busy}, 256'd0);
        chk("arst_ready", {255'd0, psum_ready}, 256'd0);
        chk("arst_valid", {255'd0, out_valid}, 256'd0);
        chk("arst_data", out_data, 256'd0);
        chk("arst_mode", {254'd0, out_mode}, 256'd0);
        @(negedge clk);
        psum_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        job_beats.delete();
        job_beats.push_back(52'd7);
        run_job(4'b1000, 1'b0, 1, 1'b0);
        finish_job({64'd0, 64'd0, 64'd0, 64'd7}, 2'd0);

        // Full-range pass counter.
        job_beats.delete();
        for (int k = 0; k < 65535; k++) job_beats.push_back(52'd1);
        run_job(4'b1000, 1'b0, 65535, 1'b0);
        finish_job({64'd0, 64'd0, 64'd0, 64'd65535}, 2'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
